serial_add_sub: RTL and testbench

//  Bit-serial WIDTH-bit adder/subtractor built around one fullAdder cell and a carry flop.

---
 rtl/add_sub_pkg.sv | 9 +
 rtl/fullAdder.sv | 13 +
 rtl/serial_add_sub.sv | 94 +++++++++
 tb/tb_serial_add_sub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared state encoding and operation codes for serial_add_sub
package add_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} as_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fullAdder.sv
// rtl/fullAdder.sv - one-bit full adder cell used by the serial datapath
module fullAdder (
  input  logic In1,
  input  logic In2,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = In1 ^ In2 ^ Cin;
  assign Cout = (In1 & In2) | (In1 & Cin) | (In2 & Cin);

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial add/subtract, LSB first, one full adder plus carry flop
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  as_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             sum_bit;
  logic             cout_bit;
  logic             accept;
  logic             is_sub;

  fullAdder u_fa (
    .In1  (a_sh[0]),
    .In2  (b_sh[0]),
    .Cin  (carry),
    .Sum  (sum_bit),
    .Cout (cout_bit)
  );

  // Partial result lives in res_sh so the visible result only changes on completion.
  assign res_next  = (res_sh >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_sub    = (sub == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      bit_cnt  <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b ^ {WIDTH{is_sub}};
            carry   <= is_sub;
            bit_cnt <= '0;
            state   <= RUN;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= cout_bit;
          if (bit_cnt == LAST) begin
            result   <= res_next;
            cout     <= cout_bit;
            overflow <= carry ^ cout_bit;
            state    <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed vector bench for serial_add_sub (WIDTH=8 and WIDTH=1)
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       overflow;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       sub1;
  logic       out_valid1;
  logic [0:0] result1;
  logic       cout1;
  logic       overflow1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  serial_add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .cout(cout1), .overflow(overflow1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation and counts edges until out_valid (bounded).
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int t1, t2, cyc;
  bit seen1, seen2, dropped, ready_in_done, stray;

  initial begin
    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_cout", cout, 0);
    check("reset_overflow", overflow, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_result", i), result, vecs[i].result);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
    end
    @(posedge clk); #1;

    // Backpressure: result must hold and in_valid pulses must be ignored.
    @(negedge clk); out_ready = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, lat);
    check("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'hAA; b = 8'h55; sub = 1'b1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold_result%0d", i), result, 8'h46);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_idle", in_ready, 1);
    check("bp_result_kept", result, 8'h46);
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_extra_op", out_valid, 0);

    // Back-to-back: in_valid held, second accept happens in the DONE cycle.
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; in_valid = 1'b1;
    cyc = 0; seen1 = 0; seen2 = 0; dropped = 0; ready_in_done = 0; t1 = 0; t2 = 0;
    while (!seen2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin a = 8'h50; b = 8'h60; sub = 1'b1; end
      if (seen1 && !dropped) begin in_valid = 1'b0; dropped = 1; end
      if (out_valid && !seen1) begin
        seen1 = 1; t1 = cyc; ready_in_done = in_ready;
        check("b2b_first_result", result, 8'h30);
      end else if (out_valid && seen1 && dropped) begin
        seen2 = 1; t2 = cyc;
        check("b2b_second_result", result, 8'hF0);
        check("b2b_second_cout", cout, 0);
      end
    end
    check("b2b_seen_second", seen2, 1);
    check("b2b_ready_in_done", ready_in_done, 1);
    check("b2b_first_latency", t1, 9);
    check("b2b_spacing", t2 - t1, 9);
    @(posedge clk); #1;

    // Reset during the third RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1;
    end
    check("abort_no_stale_valid", stray, 0);

    // WIDTH=1: single RUN cycle.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1; in_valid1 = 1'b0;
    @(posedge clk); #1;
    check("w1_add_valid", out_valid1, 1);
    check("w1_add_result", result1, 0);
    check("w1_add_cout", cout1, 1);
    check("w1_add_overflow", overflow1, 1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; sub1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1; in_valid1 = 1'b0;
    @(posedge clk); #1;
    check("w1_sub_valid", out_valid1, 1);
    check("w1_sub_result", result1, 1);
    check("w1_sub_cout", cout1, 0);
    check("w1_sub_overflow", overflow1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
